// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based hazard controller for the decode stage.
// Tracks in-flight register writes from loads and multiplies with one small
// down-counter per architectural register. A decode instruction that reads a
// register whose counter is non-zero stalls fetch/decode and bubbles EX.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   id_valid          decode holds a real instruction
//   id_src_reg1/2     source registers; id_uses_reg2 qualifies src2
//   id_dest_reg       destination register, id_regwrite qualifies it
//   id_memread        instruction is a load
//   id_is_mult        instruction is a multiply
//   id_is_jump        instruction is a jump
//   stall             bubble into EX (combinational)
//   pc_we, ifid_we    fetch PC / decode-stage write enables (combinational)
//   flush_if          squash the fetch slot behind an issuing jump (combinational)
//   mult_busy         some register has a multiply write pending (combinational)
//   stall_cycles      registered saturating count of stall cycles
module hazard_ctrl #(
    parameter int unsigned REG_ADDR = 5,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned PERF_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_ADDR-1:0] id_src_reg1,
    input  logic [REG_ADDR-1:0] id_src_reg2,
    input  logic                id_uses_reg2,
    input  logic [REG_ADDR-1:0] id_dest_reg,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                id_is_mult,
    input  logic                id_is_jump,
    output logic                stall,
    output logic                pc_we,
    output logic                ifid_we,
    output logic                flush_if,
    output logic                mult_busy,
    output logic [PERF_W-1:0]   stall_cycles
);

    localparam int unsigned NREG = 1 << REG_ADDR;

    logic [CNT_W-1:0]  busy_cnt_q [NREG];
    logic [CNT_W-1:0]  busy_cnt_d [NREG];
    logic [NREG-1:0]   busy_mul_q;
    logic [NREG-1:0]   busy_mul_d;
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    logic              haz1;
    logic              haz2;
    logic              issue;
    logic              wr_en;
    logic [CNT_W-1:0]  wr_lat;

    // Hazard detection; reset masks any stale scoreboard state in its own cycle
    always_comb begin
        haz1 = id_valid && (id_src_reg1 != '0) && (busy_cnt_q[id_src_reg1] != '0);
        haz2 = id_valid && id_uses_reg2 && (id_src_reg2 != '0)
               && (busy_cnt_q[id_src_reg2] != '0);
        stall     = !reset && (haz1 || haz2);
        pc_we     = !stall;
        ifid_we   = !stall;
        issue     = id_valid && !stall;
        flush_if  = !reset && issue && id_is_jump;
        mult_busy = !reset && (|busy_mul_q);
    end

    // Scoreboard load request: register 0 is never tracked
    always_comb begin
        wr_en  = issue && id_regwrite && (id_dest_reg != '0);
        wr_lat = '0;
        if (id_is_mult) begin
            wr_lat = CNT_W'(MUL_LAT);
        end else if (id_memread) begin
            wr_lat = CNT_W'(LOAD_LAT);
        end
    end

    // Per-register next state: decrement, then a new write overrides (youngest wins)
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        logic [CNT_W-1:0] dec;
        logic             hit;

        assign dec = (busy_cnt_q[r] != '0) ? busy_cnt_q[r] - CNT_W'(1) : busy_cnt_q[r];
        assign hit = wr_en && (id_dest_reg == REG_ADDR'(r));

        assign busy_cnt_d[r] = hit ? wr_lat : dec;
        assign busy_mul_d[r] = hit ? id_is_mult : (busy_mul_q[r] && (dec != '0));
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt_q     <= '{default: '0};
            busy_mul_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            busy_cnt_q     <= busy_cnt_d;
            busy_mul_q     <= busy_mul_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a
// ready-time model (each register becomes readable at an absolute cycle).
module tb_hazard_ctrl;

    localparam int unsigned LOAD_LAT = 1;
    localparam int unsigned MUL_LAT  = 4;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_src_reg1;
    logic [4:0] id_src_reg2;
    logic       id_uses_reg2;
    logic [4:0] id_dest_reg;
    logic       id_regwrite;
    logic       id_memread;
    logic       id_is_mult;
    logic       id_is_jump;
    logic       stall;
    logic       pc_we;
    logic       ifid_we;
    logic       flush_if;
    logic       mult_busy;
    logic [15:0] stall_cycles;

    hazard_ctrl #(
        .REG_ADDR (5),
        .CNT_W    (4),
        .LOAD_LAT (LOAD_LAT),
        .MUL_LAT  (MUL_LAT),
        .PERF_W   (16)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_src_reg1  (id_src_reg1),
        .id_src_reg2  (id_src_reg2),
        .id_uses_reg2 (id_uses_reg2),
        .id_dest_reg  (id_dest_reg),
        .id_regwrite  (id_regwrite),
        .id_memread   (id_memread),
        .id_is_mult   (id_is_mult),
        .id_is_jump   (id_is_jump),
        .stall        (stall),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .flush_if     (flush_if),
        .mult_busy    (mult_busy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk;
    int unsigned n_err;

    // Reference model: absolute ready cycle per register
    longint      cyc;
    longint      ready_at [32];
    bit          is_mul   [32];
    int unsigned perf;

    bit last_stall;
    bit last_flush;
    bit last_mb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit busy(input int r);
        return (r != 0) && (cyc < ready_at[r]);
    endfunction

    function automatic bit mul_pending();
        for (int r = 1; r < 32; r++) begin
            if (is_mul[r] && cyc < ready_at[r]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: drive at negedge, check combinational outputs, update model at posedge
    task automatic step(input bit v, input int s1, input int s2, input bit u2, input int d,
                        input bit rw, input bit mr, input bit ml, input bit j, input bit rs);
        bit exp_stall;
        bit exp_mb;
        bit exp_flush;
        int lat;
        id_valid     = v;
        id_src_reg1  = 5'(s1);
        id_src_reg2  = 5'(s2);
        id_uses_reg2 = u2;
        id_dest_reg  = 5'(d);
        id_regwrite  = rw;
        id_memread   = mr;
        id_is_mult   = ml;
        id_is_jump   = j;
        reset        = rs;
        #1;
        exp_stall = !rs && v && (busy(s1) || (u2 && busy(s2)));
        exp_mb    = !rs && mul_pending();
        exp_flush = !rs && v && !exp_stall && j;
        check("stall", 32'(stall), 32'(exp_stall));
        check("pc_we", 32'(pc_we), 32'(!exp_stall));
        check("ifid_we", 32'(ifid_we), 32'(!exp_stall));
        check("flush_if", 32'(flush_if), 32'(exp_flush));
        check("mult_busy", 32'(mult_busy), 32'(exp_mb));
        check("stall_cycles", 32'(stall_cycles), perf);
        last_stall = stall;
        last_flush = flush_if;
        last_mb    = mult_busy;
        @(posedge clk);
        if (rs) begin
            for (int r = 0; r < 32; r++) begin
                ready_at[r] = 0;
                is_mul[r]   = 1'b0;
            end
            perf = 0;
        end else begin
            if (exp_stall && perf != 32'hFFFF) perf++;
            if (v && !exp_stall && rw && d != 0) begin
                lat = ml ? int'(MUL_LAT) : (mr ? int'(LOAD_LAT) : 0);
                ready_at[d] = cyc + 1 + lat;
                is_mul[d]   = ml;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int n;
    bit bad_flush;
    int r_s1, r_s2, r_d;
    bit r_v, r_u2, r_rw, r_mr, r_ml, r_j;

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        perf  = 0;
        for (int r = 0; r < 32; r++) begin
            ready_at[r] = 0;
            is_mul[r]   = 1'b0;
        end
        reset = 1'b1;
        id_valid = 1'b0; id_src_reg1 = '0; id_src_reg2 = '0; id_uses_reg2 = 1'b0;
        id_dest_reg = '0; id_regwrite = 1'b0; id_memread = 1'b0; id_is_mult = 1'b0;
        id_is_jump = 1'b0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        nop(1);
        check("rst_stall_cycles", 32'(stall_cycles), 32'd0);

        // Load r3 then dependent reader: exactly one stall
        step(1, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        step(1, 3, 0, 0, 8, 1, 0, 0, 0, 0);
        check("t1_stall", 32'(last_stall), 32'd1);
        step(1, 3, 0, 0, 8, 1, 0, 0, 0, 0);
        check("t1_issue", 32'(last_stall), 32'd0);
        check("t1_perf", 32'(stall_cycles), 32'd1);

        // Mult r5 then src2 reader: four stalls, mult_busy throughout
        step(1, 0, 0, 0, 5, 1, 0, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 5, 1, 9, 1, 0, 0, 0, 0);
            if (!last_stall) break;
            check("t2_mb", 32'(last_mb), 32'd1);
            n++;
        end
        check("t2_stalls", 32'(n), 32'(MUL_LAT));
        step(1, 0, 0, 0, 5, 1, 0, 1, 0, 0);
        step(1, 0, 5, 0, 9, 1, 0, 0, 0, 0);
        check("t2_no_use2", 32'(last_stall), 32'd0);
        nop(6);

        // r0 never busy; ALU producer needs no stall
        step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 9, 1, 0, 0, 0, 0);
        check("t3_r0", 32'(last_stall), 32'd0);
        step(1, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        step(1, 7, 7, 1, 9, 1, 0, 0, 0, 0);
        check("t3_alu", 32'(last_stall), 32'd0);

        // WAW: younger load overrides older mult on r2
        step(1, 0, 0, 0, 2, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 2, 1, 1, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 2, 0, 0, 9, 1, 0, 0, 0, 0);
            if (i == 0) check("t4_mb", 32'(last_mb), 32'd0);
            if (!last_stall) break;
            n++;
        end
        check("t4_stalls", 32'(n), 32'(LOAD_LAT));

        // Stalled jump flushes only on its issue cycle
        step(1, 0, 0, 0, 4, 1, 0, 1, 0, 0);
        n = 0;
        bad_flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1, 4, 0, 0, 0, 0, 0, 0, 1, 0);
            if (!last_stall) break;
            if (last_flush) bad_flush = 1'b1;
            n++;
        end
        check("t5_no_flush_stalled", 32'(bad_flush), 32'd0);
        check("t5_flush_issue", 32'(last_flush), 32'd1);
        check("t5_stalls", 32'(n), 32'(MUL_LAT));
        nop(6);

        // Reset mid-stall forgets pending mult
        step(1, 0, 0, 0, 6, 1, 0, 1, 0, 0);
        step(1, 6, 0, 0, 9, 1, 0, 0, 0, 0);
        check("t6_stall1", 32'(last_stall), 32'd1);
        step(1, 6, 0, 0, 9, 1, 0, 0, 0, 1);
        check("t6_rst_stall", 32'(last_stall), 32'd0);
        step(1, 6, 0, 0, 9, 1, 0, 0, 0, 0);
        check("t6_after_stall", 32'(last_stall), 32'd0);
        check("t6_after_mb", 32'(last_mb), 32'd0);
        check("t6_after_perf", 32'(stall_cycles), 32'd0);

        // Random traffic; a stalled instruction is held in decode
        last_stall = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!last_stall) begin
                r_v  = ($urandom % 8) != 0;
                r_s1 = $urandom % 8;
                r_s2 = $urandom % 8;
                r_d  = $urandom % 8;
                r_u2 = $urandom % 2;
                r_rw = ($urandom % 4) != 0;
                r_mr = ($urandom % 3) == 0;
                r_ml = ($urandom % 4) == 0;
                r_j  = ($urandom % 6) == 0;
            end
            step(r_v, r_s1, r_s2, r_u2, r_d, r_rw, r_mr, r_ml, r_j, ($urandom % 300) == 0);
        end

        // Saturation: self-dependent mult stalls 4 of every 5 cycles
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 82000; i++) begin
            step(1, 5, 0, 0, 5, 1, 0, 1, 0, 0);
        end
        check("sat_perf", 32'(stall_cycles), 32'h0000FFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Scoreboard-based hazard controller for the decode stage. It tracks in-flight register writes from loads and multiplies. When an instruction in decode reads a register that is not yet forwardable, it stalls fetch/decode and injects a bubble into EX. It also flushes the fetch slot when a jump leaves decode. It drives the decode stage's `we` and `stall` inputs, and the fetch PC write-enable.

Parameters:
REG_ADDR, 5, register address width (32 architectural registers)
CNT_W, 4, width of each per-register busy counter
LOAD_LAT, 1, stall cycles a load-dependent instruction must wait
MUL_LAT, 4, stall cycles a mult-dependent instruction must wait (must be < 2**CNT_W)
PERF_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  decode holds a real instruction
id_src_reg1  in  REG_ADDR  source register 1 (instr[25:21])
id_src_reg2  in  REG_ADDR  source register 2 (instr[20:16])
id_uses_reg2  in  1  instruction reads src_reg2
id_dest_reg  in  REG_ADDR  destination register
id_regwrite  in  1  instruction writes a register
id_memread  in  1  instruction is a load
id_is_mult  in  1  instruction is a multiply
id_is_jump  in  1  instruction is a jump
stall  out  1  to decode/control: insert bubble into EX
pc_we  out  1  fetch PC write-enable
ifid_we  out  1  decode-stage `we`
flush_if  out  1  squash the instruction leaving fetch
mult_busy  out  1  some register has a multiply write pending
stall_cycles  out  PERF_W  saturating count of stall cycles

Behaviour:
- State:
  - busy_cnt[0..31], CNT_W bits each.
  - busy_mul[0..31], 1 bit each.
  - stall_cycles register.
  - Register 0 is never busy. Writes to dest 0 are ignored.
- Hazard detection (combinational, same cycle):
  - haz1 = id_valid & src1!=0 & busy_cnt[src1]!=0.
  - haz2 = id_valid & id_uses_reg2 & src2!=0 & busy_cnt[src2]!=0.
  - stall = haz1 | haz2.
- Derived outputs:
  - pc_we = ifid_we = ~stall.
  - issue = id_valid & ~stall.
  - flush_if = issue & id_is_jump. It is never asserted while stalled; a stalled jump flushes on the cycle it issues.
  - mult_busy = OR of busy_mul.
- Per-register update, each rising edge (reset not asserted):
  - If busy_cnt != 0, decrement by 1. Clear busy_mul when the counter reaches 0.
  - Then, if issue & id_regwrite & dest!=0: load busy_cnt[dest] with latency.
    - latency = MUL_LAT if id_is_mult, else LOAD_LAT if id_memread, else 0.
    - busy_mul[dest] <= id_is_mult.
  - The new load overrides that register's decrement (WAW: youngest writer wins, even if shorter).
- Latency:
  - A dependent instruction that immediately follows a load stalls exactly LOAD_LAT cycles.
  - A dependent instruction that immediately follows a mult stalls exactly MUL_LAT cycles.
  - ALU producers cause 0 stall cycles (forwarding covers them).
- stall_cycles: increments on every cycle with stall=1 and saturates at all-ones. It is not cleared except by reset.
- Simultaneous events:
  - src1==src2 busy: one stall, same duration.
  - Instruction reads and writes the same busy register: stalls on the read; the write is scheduled at issue.
  - id_valid=0: no stall, no scoreboard load; counters keep decrementing.
- Reset (synchronous, active-high, also mid-operation): every counter and busy_mul clears, stall_cycles=0. In the same cycle the outputs are stall=0, pc_we=1, ifid_we=1, flush_if=0, mult_busy=0. Pending hazards are forgotten.

Test Plan:
1. Load r3 issued, next cycle an instruction reading src1=r3 → stall=1 for exactly 1 cycle, pc_we=ifid_we=0 in that cycle, issues the next cycle; stall_cycles=1.
2. Mult writing r5, then a dependent instruction reading src2=r5 with id_uses_reg2=1 → stall for 4 cycles and mult_busy=1 throughout; with id_uses_reg2=0 → no stall.
3. Load to r0, then a reader of r0 → no stall. ALU writes r7, then a reader of r7 → no stall.
4. Mult writing r2 (4), then next cycle a load writing r2 (1), then a reader of r2 → 1 stall cycle (youngest writer wins); busy_mul[r2] cleared.
5. Jump in decode while stalled on r4 → flush_if=0 while stalled, flush_if=1 exactly on the issue cycle.
6. Mult to r6, assert reset at stall cycle 2 → the next cycle has stall=0, mult_busy=0, stall_cycles=0; a reader of r6 issues immediately. Also force 2**16+5 stall cycles → stall_cycles holds 16'hFFFF.
